// File: rtl/nerf_fix_pkg.sv
// Shared fixed-point constants, FSM state type and saturation helper for the
// NeRF ray-marching back end.
package nerf_fix_pkg;

    localparam int NINT_BITS   = 12;
    localparam int NFRAC_BITS  = 4;
    localparam int NTOTAL_BITS = 16;
    localparam int N_SAMPLES   = 32;

    // Colour accumulators are 24-bit signed; headroom covers per-sample floor error
    localparam int ACC_BITS = 24;

    // 1.0 in unsigned Q1.15 (transmittance / opacity scale)
    localparam logic [15:0] Q15_ONE = 16'h8000;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } comp_state_e;

    // Clamp a 24-bit signed accumulator into a signed 16-bit Q12.4 word
    function automatic logic [15:0] sat16(input logic signed [ACC_BITS-1:0] v);
        logic [15:0] r;
        if (v > 24'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -24'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/exp_neg_lut.sv
// exp(-i/16) lookup: 256 x 16-bit synchronous ROM, Q1.15 output.
// The table is built at elaboration from integer arithmetic only:
// exp(-1/16) is summed as a Taylor series in Q0.60, then raised to
// successive powers, each entry rounded to nearest into Q1.15.
module exp_neg_lut (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  idx_i,
    input  logic        sat_i,
    output logic [15:0] e_o
);

    function automatic logic [4095:0] build_exp_lut();
        logic [63:0]   one_v;
        logic [63:0]   term_v;
        logic [63:0]   r_v;
        logic [63:0]   p_v;
        logic [127:0]  prod_v;
        logic [4095:0] tab_v;
        one_v  = 64'd1 << 60;
        term_v = one_v;
        r_v    = one_v;
        // exp(-x) with x = 1/16: term_k = term_{k-1} * x / k, alternating sign
        for (int k = 1; k < 14; k++) begin
            term_v = term_v / (64'd16 * 64'(k));
            if ((k % 2) == 1) begin
                r_v = r_v - term_v;
            end else begin
                r_v = r_v + term_v;
            end
        end
        p_v   = one_v;
        tab_v = '0;
        for (int i = 0; i < 256; i++) begin
            tab_v[i*16 +: 16] = 16'((p_v + (64'd1 << 44)) >> 45);
            prod_v = {64'd0, p_v} * {64'd0, r_v};
            p_v    = 64'((prod_v + (128'd1 << 59)) >> 60);
        end
        return tab_v;
    endfunction

    localparam logic [4095:0] EXP_TABLE = build_exp_lut();

    logic [15:0] e_q;

    // Registered ROM read; beyond the table range the attenuation is total (e = 0)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q <= 16'd0;
        end else if (sat_i) begin
            e_q <= 16'd0;
        end else begin
            e_q <= EXP_TABLE[{idx_i, 4'd0} +: 16];
        end
    end

    assign e_o = e_q;

endmodule

// File: rtl/volume_composite.sv
// Front-to-back alpha compositing of one ray's sample stream into a pixel
// colour and accumulated opacity. Two-stage pipeline: S1 forms the optical
// depth and reads exp(-x) from the ROM, S2 updates transmittance and the
// colour accumulators. One ray in flight; result held until consumed.
module volume_composite #(
    parameter int N_SAMPLES  = nerf_fix_pkg::N_SAMPLES,
    parameter int INT_BITS   = nerf_fix_pkg::NINT_BITS,
    parameter int FRAC_BITS  = nerf_fix_pkg::NFRAC_BITS,
    parameter int TOTAL_BITS = INT_BITS + FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [TOTAL_BITS-1:0]   s_sigma,
    input  logic [TOTAL_BITS-1:0]   s_delta,
    input  logic [3*TOTAL_BITS-1:0] s_rgb,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [3*TOTAL_BITS-1:0] m_rgb,
    output logic [15:0]             m_acc
);

    import nerf_fix_pkg::*;

    localparam int CNT_W = $clog2(N_SAMPLES);

    comp_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      drain_q, drain_d;
    logic                      s_ready_q;
    logic                      m_valid_q;
    logic [3*TOTAL_BITS-1:0]   m_rgb_q;
    logic [15:0]               m_acc_q;

    logic                      v1_q;
    logic [3*TOTAL_BITS-1:0]   rgb1_q;

    logic [15:0]               t_q, t_d;
    logic signed [ACC_BITS-1:0] acc_q [3];
    logic signed [ACC_BITS-1:0] acc_d [3];

    logic                      accept_s;
    logic [TOTAL_BITS-1:0]     sigma_pos_s;
    logic [31:0]               x_s;
    logic [7:0]                idx_s;
    logic                      sat_s;
    logic [15:0]               e_s;
    logic [15:0]               alpha_s;
    logic [15:0]               w_s;
    logic signed [ACC_BITS-1:0] contrib_s [3];

    assign accept_s = s_valid & s_ready_q;

    // S1 combinational: clamp density at zero, optical depth x (8 fraction bits), LUT index
    always_comb begin
        sigma_pos_s = '0;
        x_s         = 32'd0;
        idx_s       = 8'd0;
        sat_s       = 1'b0;
        if (s_sigma[TOTAL_BITS-1]) begin
            sigma_pos_s = '0;
        end else begin
            sigma_pos_s = s_sigma;
        end
        x_s   = 32'(sigma_pos_s) * 32'(s_delta);
        idx_s = 8'(x_s >> FRAC_BITS);
        sat_s = (x_s >> (FRAC_BITS + 8)) != 32'd0;
    end

    exp_neg_lut u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .idx_i (idx_s),
        .sat_i (sat_s),
        .e_o   (e_s)
    );

    // S2 combinational: sample weight and per-channel colour contribution
    always_comb begin
        alpha_s = Q15_ONE - e_s;
        w_s     = 16'((32'(t_q) * 32'(alpha_s)) >> 15);
        for (int c = 0; c < 3; c++) begin
            contrib_s[c] = 24'(($signed(33'(w_s)) *
                                33'($signed(rgb1_q[c*TOTAL_BITS +: TOTAL_BITS]))) >>> 15);
        end
    end

    // Transmittance / accumulator next state: reinit on result handshake, else integrate
    always_comb begin
        t_d = t_q;
        for (int c = 0; c < 3; c++) begin
            acc_d[c] = acc_q[c];
        end
        if ((state_q == OUT) && m_ready) begin
            t_d = Q15_ONE;
            for (int c = 0; c < 3; c++) begin
                acc_d[c] = '0;
            end
        end else if (v1_q) begin
            t_d = t_q - w_s;
            for (int c = 0; c < 3; c++) begin
                acc_d[c] = acc_q[c] + contrib_s[c];
            end
        end else begin
            t_d = t_q;
        end
    end

    // Ray FSM next state: count samples, wait two cycles for the pipeline, hold result
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            ACC: begin
                drain_d = 1'b0;
                if (accept_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = OUT;
                end else begin
                    state_d = DRAIN;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = ACC;
                cnt_d   = '0;
                drain_d = 1'b0;
            end
        endcase
    end

    // Control, pipeline and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ACC;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_rgb_q   <= '0;
            m_acc_q   <= 16'd0;
            v1_q      <= 1'b0;
            rgb1_q    <= '0;
            t_q       <= Q15_ONE;
            for (int c = 0; c < 3; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            s_ready_q <= (state_d == ACC);
            m_valid_q <= (state_d == OUT);
            v1_q      <= accept_s;
            if (accept_s) begin
                rgb1_q <= s_rgb;
            end
            t_q <= t_d;
            for (int c = 0; c < 3; c++) begin
                acc_q[c] <= acc_d[c];
            end
            if ((state_q == DRAIN) && (state_d == OUT)) begin
                m_rgb_q <= {sat16(acc_q[2]), sat16(acc_q[1]), sat16(acc_q[0])};
                m_acc_q <= Q15_ONE - t_q;
            end
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_rgb   = m_rgb_q;
    assign m_acc   = m_acc_q;

endmodule

// File: tb/tb_volume_composite.sv
// Directed testbench for volume_composite. Hand-derived constants for the
// simple rays, plus a reference model (exp table from real-valued $exp) for
// the bit-exact rays.
module tb_volume_composite;

    localparam logic [47:0] RGB0 = 48'h0030_0020_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_sigma;
    logic [15:0] s_delta;
    logic [47:0] s_rgb;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_rgb;
    logic [15:0] m_acc;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lut [256];
    logic [15:0] sig_a [32];
    logic [15:0] del_a [32];
    logic [47:0] rgb_a [32];
    logic [47:0] exp_rgb;
    logic [15:0] exp_acc;

    always #5 clk = ~clk;

    volume_composite dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sigma (s_sigma),
        .s_delta (s_delta),
        .s_rgb   (s_rgb),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rgb   (m_rgb),
        .m_acc   (m_acc)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference compositing of the 32 samples in sig_a/del_a/rgb_a
    task automatic model_ray();
        longint t, w, e, x, sp, alpha, ch;
        longint acc [3];
        t = 32768;
        for (int c = 0; c < 3; c++) acc[c] = 0;
        for (int k = 0; k < 32; k++) begin
            sp = longint'($signed(sig_a[k]));
            if (sp < 0) sp = 0;
            x = sp * longint'(del_a[k]);
            if (x >= 4096) e = 0;
            else e = longint'(lut[x / 16]);
            alpha = 32768 - e;
            w = (t * alpha) / 32768;
            t = t - w;
            for (int c = 0; c < 3; c++) begin
                ch = longint'($signed(rgb_a[k][c*16 +: 16]));
                acc[c] = acc[c] + ((w * ch) >>> 15);
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (acc[c] > 32767) exp_rgb[c*16 +: 16] = 16'h7FFF;
            else if (acc[c] < -32768) exp_rgb[c*16 +: 16] = 16'h8000;
            else exp_rgb[c*16 +: 16] = 16'(acc[c]);
        end
        exp_acc = 16'(32768 - t);
    endtask

    task automatic fill_const(input logic [15:0] sg, input logic [15:0] dl, input logic [47:0] rg);
        for (int k = 0; k < 32; k++) begin
            sig_a[k] = sg;
            del_a[k] = dl;
            rgb_a[k] = rg;
        end
    endtask

    task automatic fill_random();
        int sg;
        for (int k = 0; k < 32; k++) begin
            sg = int'($urandom_range(0, 200));
            if ($urandom_range(0, 4) == 0) sg = -sg;
            sig_a[k] = 16'(sg);
            del_a[k] = 16'($urandom_range(0, 16));
            rgb_a[k] = {16'($urandom), 16'($urandom), 16'($urandom)};
        end
    endtask

    // Push n samples (optionally with s_valid gaps); optionally keep junk on the bus after
    task automatic send_ray(input bit gaps, input int n, input bit junk);
        int k;
        int guard;
        bit acc_now;
        k = 0;
        guard = 0;
        while (k < n && guard < 1000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_sigma = sig_a[k];
                s_delta = del_a[k];
                s_rgb   = rgb_a[k];
            end
            acc_now = s_valid && s_ready;
            tick();
            guard++;
            if (acc_now) k++;
        end
        check_eq("send_count", 64'(k), 64'(n));
        if (junk) begin
            s_valid = 1'b1;
            s_sigma = 16'h0100;
            s_delta = 16'h0100;
            s_rgb   = 48'h7FFF_7FFF_7FFF;
        end else begin
            s_valid = 1'b0;
        end
    endtask

    // Full ray, then wait for m_valid; it must appear two edges after the last accept edge
    task automatic do_ray(input bit gaps, input bit junk);
        int lat;
        send_ray(gaps, 32, junk);
        lat = 0;
        while (m_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        check_eq("m_valid_rise", 64'(m_valid), 64'd1);
        check_eq("latency", 64'(lat), 64'd2);
    endtask

    task automatic finish_ray(input string tag);
        model_ray();
        check_eq({tag, "_rgb"}, m_rgb, exp_rgb);
        check_eq({tag, "_acc"}, 64'(m_acc), 64'(exp_acc));
        m_ready = 1'b1;
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        check_eq({tag, "_mvalid_drop"}, 64'(m_valid), 64'd0);
        check_eq({tag, "_sready_next"}, 64'(s_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sready"}, 64'(s_ready), 64'd0);
        check_eq({tag, "_mvalid"}, 64'(m_valid), 64'd0);
        check_eq({tag, "_mrgb"}, m_rgb, 64'd0);
        check_eq({tag, "_macc"}, 64'(m_acc), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            lut[i] = int'($floor(32768.0 * $exp(-real'(i) / 16.0) + 0.5));
        end
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_sigma = 16'h0000;
        s_delta = 16'h0000;
        s_rgb   = 48'h0;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_eq("sready_after_reset", 64'(s_ready), 64'd1);

        // Zero density: nothing absorbed, nothing emitted
        fill_const(16'h0000, 16'h0010, RGB0);
        do_ray(1'b0, 1'b0);
        check_eq("zero_rgb_const", m_rgb, 64'd0);
        check_eq("zero_acc_const", 64'(m_acc), 64'd0);
        finish_ray("zero");

        // Opaque first sample: x = 100.0 saturates, w = 1.0, later samples weigh 0
        fill_random();
        sig_a[0] = 16'h0640;
        del_a[0] = 16'h0010;
        rgb_a[0] = RGB0;
        do_ray(1'b1, 1'b0);
        check_eq("opaque_rgb_const", m_rgb, 64'(RGB0));
        check_eq("opaque_acc_const", 64'(m_acc), 64'h8000);
        finish_ray("opaque");

        // Negative density clamps to zero
        fill_random();
        for (int k = 0; k < 32; k++) begin
            sig_a[k] = 16'hFFB0;
            del_a[k] = 16'h0010;
        end
        do_ray(1'b0, 1'b0);
        check_eq("neg_rgb_const", m_rgb, 64'd0);
        check_eq("neg_acc_const", 64'(m_acc), 64'd0);
        finish_ray("neg");

        // Single small-step sample: x = 1/16, i = 1, e = round(30782.69) = 30783,
        // alpha = 1985, w = 1985, r contribution floor(1985*1600/32768) = 96
        fill_const(16'h0000, 16'h0010, 48'h0);
        sig_a[0] = 16'h0010;
        del_a[0] = 16'h0001;
        rgb_a[0] = 48'h0000_0000_0640;
        do_ray(1'b0, 1'b0);
        check_eq("step1_rgb_const", m_rgb, 64'h0000_0000_0060);
        check_eq("step1_acc_const", 64'(m_acc), 64'd1985);
        finish_ray("step1");

        // Small step on every sample, bit-exact against the model
        fill_const(16'h0010, 16'h0001, 48'h0000_0000_0640);
        do_ray(1'b0, 1'b0);
        finish_ray("step32");

        // Mixed ray, junk on the input during DRAIN/OUT, result backpressured 10 cycles
        fill_random();
        do_ray(1'b1, 1'b1);
        model_ray();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_mvalid", 64'(m_valid), 64'd1);
            check_eq("bp_rgb", m_rgb, exp_rgb);
            check_eq("bp_acc", 64'(m_acc), 64'(exp_acc));
            check_eq("bp_sready", 64'(s_ready), 64'd0);
        end
        finish_ray("bp");

        // Next ray right after the handshake: proves no junk sample was consumed
        fill_random();
        do_ray(1'b0, 1'b0);
        finish_ray("after_bp");

        // Reset mid-ray after 10 samples with gaps
        fill_random();
        send_ray(1'b1, 10, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("midray_rst");
        rst_n = 1'b1;
        tick();
        check_eq("midray_sready", 64'(s_ready), 64'd1);
        fill_random();
        do_ray(1'b1, 1'b0);
        finish_ray("post_rst");

        // Reset while holding a result: it is discarded
        fill_random();
        do_ray(1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("out_rst");
        rst_n = 1'b1;
        tick();
        fill_random();
        do_ray(1'b1, 1'b0);
        finish_ray("post_out_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
